// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Brief    : Decodes UART RX bytes into SD-card block read/write commands,
//            forwards write data to the card driver and multiplexes driver
//            result bytes with injected status bytes onto UART TX.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
  parameter int         BLOCK_LEN = 512,
  parameter logic [7:0] CMD_WR    = 8'h57,
  parameter logic [7:0] CMD_RD    = 8'h52,
  parameter logic [7:0] ST_OK     = 8'h4B,
  parameter logic [7:0] ST_BAD    = 8'h3F,
  parameter logic [7:0] ST_TMO    = 8'h54,
  parameter int         TIMEOUT   = 50000000
) (
  input  logic        CLOCK50,
  input  logic        RESET,
  input  logic        RX_STB,
  input  logic [7:0]  RX_DAT,
  output logic        RX_ACK,
  output logic        UTX_STB,
  output logic [7:0]  UTX_DAT,
  input  logic        UTX_ACK,
  output logic        WR_STB,
  output logic [31:0] WR_ADDR,
  input  logic        WR_ACK,
  output logic        WD_STB,
  output logic [7:0]  WD_DATA,
  input  logic        WD_ACK,
  output logic        RD_STB,
  output logic [31:0] RD_ADDR,
  input  logic        RD_ACK,
  input  logic        RES_STB,
  input  logic [7:0]  RES_DATA,
  output logic        RES_ACK,
  output logic        BUSY
);

  // Byte counter covers both the 4 address bytes and the data block.
  localparam int CNT_W = (BLOCK_LEN > 4) ? $clog2(BLOCK_LEN) : 2;
  localparam int TMO_W = 26;
  localparam logic [CNT_W-1:0] c_last_byte = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] c_last_addr = CNT_W'(3);
  localparam logic [TMO_W-1:0] c_tmo_last  = TMO_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_WR_CMD  = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_RD_CMD  = 3'd4;
  localparam logic [2:0] S_STATUS  = 3'd5;

  logic [2:0]       state_q,   state_d;
  logic             is_wr_q,   is_wr_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [23:0]      addr_q,    addr_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      rd_addr_q, rd_addr_d;
  logic             wr_stb_q,  wr_stb_d;
  logic             rd_stb_q,  rd_stb_d;
  logic [7:0]       status_q,  status_d;
  logic [TMO_W-1:0] tmo_q,     tmo_d;
  logic             inj_q,     inj_d;

  // Only three address bytes need storing; the fourth completes the word.
  logic [31:0] addr_full;
  assign addr_full = {addr_q, RX_DAT};

  // State and datapath registers; reset drops both command strobes at once.
  always_ff @(posedge CLOCK50 or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      status_q  <= 8'h00;
      tmo_q     <= '0;
      inj_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      status_q  <= status_d;
      tmo_q     <= tmo_d;
      inj_q     <= inj_d;
    end
  end

  // Next-state, counters and timeout; the idle counter defaults to clear so
  // every accepted byte and every state entry restarts it.
  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    status_d  = status_q;
    tmo_d     = '0;
    inj_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RX_STB) begin
          if (RX_DAT == CMD_WR || RX_DAT == CMD_RD) begin
            is_wr_d = (RX_DAT == CMD_WR);
            cnt_d   = '0;
            state_d = S_ADDR;
          end else begin
            status_d = ST_BAD;
            state_d  = S_STATUS;
          end
        end
      end
      S_ADDR: begin
        if (RX_STB) begin
          addr_d = addr_full[23:0];
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == c_last_addr) begin
            cnt_d = '0;
            if (is_wr_q) begin
              wr_addr_d = addr_full;
              state_d   = S_WR_CMD;
            end else begin
              rd_addr_d = addr_full;
              state_d   = S_RD_CMD;
            end
          end
        end else if (tmo_q == c_tmo_last) begin
          cnt_d    = '0;
          status_d = ST_TMO;
          state_d  = S_STATUS;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WR_CMD: begin
        if (WR_ACK) begin
          cnt_d   = '0;
          state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (RX_STB && WD_ACK) begin
          if (cnt_q == c_last_byte) begin
            cnt_d    = '0;
            status_d = ST_OK;
            state_d  = S_STATUS;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_q == c_tmo_last) begin
          // Partial block is dropped; the driver simply sees no more bytes.
          cnt_d    = '0;
          status_d = ST_TMO;
          state_d  = S_STATUS;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RD_CMD: begin
        if (RD_ACK) begin
          state_d = S_IDLE;
        end
      end
      S_STATUS: begin
        // Wait for a gap in result bytes, then keep the status selected
        // until it is taken so a result byte is never split.
        if (inj_q || !RES_STB) begin
          if (UTX_ACK) begin
            state_d = S_IDLE;
          end else begin
            inj_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    wr_stb_d = (state_d == S_WR_CMD);
    rd_stb_d = (state_d == S_RD_CMD);
  end

  // Output decode: RX acceptance, write-data forwarding and the TX mux.
  always_comb begin
    RX_ACK  = 1'b0;
    WD_STB  = 1'b0;
    WD_DATA = RX_DAT;
    UTX_STB = RES_STB;
    UTX_DAT = RES_DATA;
    RES_ACK = UTX_ACK;
    case (state_q)
      S_IDLE, S_ADDR: RX_ACK = RX_STB;
      S_WR_DATA: begin
        WD_STB = RX_STB;
        RX_ACK = WD_ACK;
      end
      S_STATUS: begin
        if (inj_q || !RES_STB) begin
          UTX_STB = 1'b1;
          UTX_DAT = status_q;
          RES_ACK = 1'b0;
        end
      end
      default: RX_ACK = 1'b0;
    endcase
  end

  assign WR_STB  = wr_stb_q;
  assign RD_STB  = rd_stb_q;
  assign WR_ADDR = wr_addr_q;
  assign RD_ADDR = rd_addr_q;
  assign BUSY    = (state_q != S_IDLE);

endmodule
`default_nettype wire
